arm_code_emitter: RTL and testbench
===================================

# arm_code_emitter

Write-side back end of the JIT translator. Accepts translated ARM instruction words from the translation state machine and buffers them in a small FIFO. Drains them into the output code RAM at consecutive word addresses. Drives the `waiting` back-pressure signal that the state machine samples. On flush, it pads the emitted block with ARM NOPs to a 4-word boundary and signals completion.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `ADR_W`, 10: output RAM word-address width.
- `NOP_WORD`, 32'hE1A00000: pad word (`MOV r0,r0`).

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: one-cycle pulse; begins a block at `base_adr`.
- `base_adr` input ADR_W: first write address, sampled on `start`.
- `cmd_valid` input 1: `cmd_word` is valid this cycle.
- `cmd_word` input 32: ARM template word from the command ROM.
- `cmd_imm_en` input 1: merge `imm_data` into the word (see Configuration).
- `imm_data` input 8: immediate byte taken from the JVM parameter.
- `flush` input 1: one-cycle pulse; ends the current block.
- `oram_ready` input 1: output RAM can accept a write this cycle.
- `waiting` output 1: producer must hold; registered.
- `oram_we` output 1: write strobe; registered.
- `oram_adr` output ADR_W: write address; registered.
- `oram_data` output 32: write data; registered.
- `done` output 1: one-cycle pulse when padding is complete.
- `oram_ovf` output 1: sticky flag; the address wrapped during this block.

## Operation
- FSM states:
  - IDLE: `waiting`=1; cmds ignored; `start` → RUN.
  - RUN: accept and drain; `flush` → DRAIN.
  - DRAIN: `waiting`=1, no accepts; FIFO empty → PAD.
  - PAD: write `NOP_WORD` while `wr_adr[1:0]`≠0; when aligned → DONE.
  - DONE: `done`=1 for one cycle → IDLE.
- `start` loads `wr_adr`←`base_adr` and clears `oram_ovf`. `start` outside IDLE is ignored.
- Push: occurs in RUN when `cmd_valid` and `!waiting`. `cmd_valid` while `waiting`=1 is ignored; the producer holds the word.
- `waiting` is registered from next-cycle occupancy: 1 when occupancy ≥ DEPTH−1, or when state ≠ RUN. This leaves one slot of slack, so the FIFO never overflows.
- Pop occurs when FIFO is non-empty and `oram_ready`=1 (RUN or DRAIN). The registered outputs load `oram_we`=1, `oram_data`=head, `oram_adr`=`wr_adr`. `wr_adr` then increments.
- With `oram_ready`=0, `oram_we`=0 next cycle and the FIFO and `wr_adr` hold.
- Push and pop in the same cycle are allowed; occupancy is unchanged.
- PAD writes also require `oram_ready`=1.
- If `flush` arrives while already aligned and the FIFO is empty, PAD writes zero words.
- Address wrap: `wr_adr` goes from 2^ADR_W−1 to 0 and sets `oram_ovf`, which holds until `start` or `reset`.
- `flush` outside RUN is ignored. `flush` coincident with an accepted push: the push is taken, then DRAIN begins.
- Reset mid-operation: the FIFO is emptied, in-flight words are discarded, and the FSM goes to IDLE.

## Timing
- Reset values: `waiting`=1, `oram_we`=0, `oram_adr`=0, `oram_data`=0, `done`=0, `oram_ovf`=0, FSM=IDLE, occupancy=0.
- Latency: a word pushed at edge E appears with `oram_we`=1 after edge E+1, given `oram_ready`=1.
- Throughput: one word per cycle sustained.
- `waiting` rises the cycle after the push that brings occupancy to DEPTH−1.
- `waiting` falls the cycle after the pop that brings occupancy below DEPTH−1.
- `done` pulses the cycle after the last PAD write, or the cycle after DRAIN empties when already aligned.

## Configuration
- `EMIT_IMM_MERGE_EN` defined: when `cmd_imm_en`=1, the pushed word is `{cmd_word[31:8], imm_data}`.
- `EMIT_IMM_MERGE_EN` not defined: `cmd_word` is pushed unchanged; `cmd_imm_en` and `imm_data` are ignored.

## Test plan
- Reset and idle: after `reset`, all outputs hold their reset values. `cmd_valid`=1 in IDLE produces no writes and `waiting`=1.
- Streaming: `start` with `base_adr`=0x010, then 3 consecutive words 0xE3A00001..3 with `oram_ready`=1. Expect writes to 0x010, 0x011, 0x012, each 2 edges after its push, and `waiting` never asserted.
- Back-pressure: `oram_ready`=0 with 5 continuous `cmd_valid`, DEPTH=4. Exactly 3 words are accepted and `waiting`=1 from the cycle after the 3rd push. Raising `oram_ready` drains them in order, `waiting` drops, and the remaining words are accepted.
- Flush and pad: 5 words from 0x020, then `flush`. Expect writes to 0x020–0x024, then NOP_WORD at 0x025–0x027, and `done` for one cycle the cycle after the 0x027 write. Expect no pad when exactly 4 words are written.
- Wrap and merge: `base_adr`=0x3FF, 2 words. Writes go to 0x3FF then 0x000, and `oram_ovf`=1. With the macro defined, `cmd_word`=0xE3A000FF, `imm_data`=0x2A and `cmd_imm_en`=1 writes 0xE3A0002A.
- Mid-op reset: assert `reset` with 3 words buffered. No further writes occur and outputs return to their reset values the next cycle.

Source files
------------

// File: rtl/arm_code_emitter.sv
// arm_code_emitter
// ----------------
// Write-side back end of the JIT translator. Translated ARM words from the
// translation state machine are buffered in a small FIFO and drained into
// the output code RAM at consecutive word addresses. On flush the block is
// padded with NOP words up to a 4-word boundary and `done` pulses.
//
// Optional feature macro: EMIT_IMM_MERGE_EN
//   defined     -> when cmd_imm_en=1 the pushed word is {cmd_word[31:8], imm_data}
//   not defined -> cmd_word is pushed unchanged; cmd_imm_en/imm_data unused
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start, base_adr     begin a block at base_adr (IDLE only)
//   cmd_valid, cmd_word producer word strobe and data
//   cmd_imm_en, imm_data immediate merge controls
//   flush               end the current block (RUN only)
//   oram_ready          output RAM accepts a write this cycle
//   waiting             registered back-pressure to the producer
//   oram_we/adr/data    registered output RAM write port
//   done                one-cycle completion pulse
//   oram_ovf            sticky address-wrap flag for this block
module arm_code_emitter #(
  parameter int          DEPTH    = 4,
  parameter int          ADR_W    = 10,
  parameter logic [31:0] NOP_WORD = 32'hE1A00000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [ADR_W-1:0] base_adr,
  input  logic             cmd_valid,
  input  logic [31:0]      cmd_word,
  input  logic             cmd_imm_en,
  input  logic [7:0]       imm_data,
  input  logic             flush,
  input  logic             oram_ready,
  output logic             waiting,
  output logic             oram_we,
  output logic [ADR_W-1:0] oram_adr,
  output logic [31:0]      oram_data,
  output logic             done,
  output logic             oram_ovf
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] HI_MARK = CNT_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_PAD,
    ST_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        mem_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ADR_W-1:0]   wr_adr_q, wr_adr_d;
  logic               ovf_q, ovf_d;
  logic               waiting_q, waiting_d;
  logic               we_q, we_d;
  logic [ADR_W-1:0]   adr_q, adr_d;
  logic [31:0]        data_q, data_d;

  logic               push, pop, pad_wr, aligned;
  logic [31:0]        fifo_in;

`ifdef EMIT_IMM_MERGE_EN
  assign fifo_in = cmd_imm_en ? {cmd_word[31:8], imm_data} : cmd_word;
`else
  logic unused_imm;
  assign unused_imm = ^{cmd_imm_en, imm_data};
  assign fifo_in    = cmd_word;
`endif

  assign aligned = (wr_adr_q[1:0] == 2'b00);
  // waiting_q already reflects next-cycle occupancy, so a push here always fits.
  assign push    = (state_q == ST_RUN) && cmd_valid && !waiting_q;
  assign pop     = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) &&
                   (count_q != '0) && oram_ready;
  assign pad_wr  = (state_q == ST_PAD) && !aligned && oram_ready;

  always_comb begin
    state_d  = state_q;
    wr_adr_d = wr_adr_q;
    ovf_d    = ovf_q;
    we_d     = 1'b0;
    adr_d    = adr_q;
    data_d   = data_q;
    count_d  = count_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_RUN;
          wr_adr_d = base_adr;
          ovf_d    = 1'b0;
        end
      end
      ST_RUN:   if (flush) state_d = ST_DRAIN;
      // Skip PAD entirely when the block already ends on a 4-word boundary.
      ST_DRAIN: if (count_q == '0) state_d = aligned ? ST_DONE : ST_PAD;
      ST_PAD:   if (aligned) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (pop || pad_wr) begin
      we_d     = 1'b1;
      adr_d    = wr_adr_q;
      data_d   = pop ? mem_q[rd_ptr_q] : NOP_WORD;
      wr_adr_d = wr_adr_q + ADR_W'(1);
      if (&wr_adr_q) ovf_d = 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    waiting_d = (state_d != ST_RUN) || (count_d >= HI_MARK);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      wr_adr_q  <= '0;
      ovf_q     <= 1'b0;
      waiting_q <= 1'b1;
      we_q      <= 1'b0;
      adr_q     <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      wr_adr_q  <= wr_adr_d;
      ovf_q     <= ovf_d;
      waiting_q <= waiting_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      data_q    <= data_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // FIFO storage needs no reset: the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= fifo_in;
  end

  assign waiting   = waiting_q;
  assign oram_we   = we_q;
  assign oram_adr  = adr_q;
  assign oram_data = data_q;
  assign done      = (state_q == ST_DONE);
  assign oram_ovf  = ovf_q;

endmodule

// File: tb/tb_arm_code_emitter.sv
// Self-checking bench for arm_code_emitter (default parameters).
module tb_arm_code_emitter;

  localparam logic [31:0] NOP = 32'hE1A00000;

  logic        clk, reset, start, cmd_valid, cmd_imm_en, flush, oram_ready;
  logic [9:0]  base_adr;
  logic [31:0] cmd_word;
  logic [7:0]  imm_data;
  logic        waiting, oram_we, done, oram_ovf;
  logic [9:0]  oram_adr;
  logic [31:0] oram_data;

  arm_code_emitter dut (
    .clk(clk), .reset(reset), .start(start), .base_adr(base_adr),
    .cmd_valid(cmd_valid), .cmd_word(cmd_word), .cmd_imm_en(cmd_imm_en),
    .imm_data(imm_data), .flush(flush), .oram_ready(oram_ready),
    .waiting(waiting), .oram_we(oram_we), .oram_adr(oram_adr),
    .oram_data(oram_data), .done(done), .oram_ovf(oram_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [9:0]  adr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t  wq[$];
  int   done_cnt = 0;
  int   done_cyc = 0;
  logic [31:0] exp_words [8];

  always @(posedge clk) cyc <= cyc + 1;

  // Write/done monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (oram_we) begin
      wq.push_back('{adr: oram_adr, data: oram_data, cyc: cyc});
      $display("[TB] cyc %0d write adr=%h data=%h", cyc, oram_adr, oram_data);
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
      $display("[TB] cyc %0d done", cyc);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_block(input logic [9:0] b);
    wq.delete();
    done_cnt = 0;
    start    = 1'b1;
    base_adr = b;
    tick();
    start    = 1'b0;
  endtask

  // Hold the word until the emitter accepts it, like the real producer.
  task automatic push_word(input logic [31:0] w, input logic ie, input logic [7:0] imm);
    int n;
    n = 0;
    cmd_valid  = 1'b1;
    cmd_word   = w;
    cmd_imm_en = ie;
    imm_data   = imm;
    @(negedge clk);
    while (waiting && n < 100) begin
      @(negedge clk);
      n = n + 1;
    end
    if (waiting) check("push_timeout", 64'(waiting), 64'(0));
    @(posedge clk);
    #1;
    cmd_valid  = 1'b0;
    cmd_imm_en = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 200) begin
      tick();
      n = n + 1;
    end
    if (done_cnt == 0) check({name, "_done_timeout"}, 64'(0), 64'(1));
    repeat (3) tick();
  endtask

  // Expected stream: data words at base.., then NOPs up to a 4-word boundary.
  task automatic verify_block(input string name, input logic [9:0] base, input int n);
    wr_t        ex[$];
    logic [9:0] a;
    int         m;
    a = base;
    for (int i = 0; i < n; i++) begin
      ex.push_back('{adr: a, data: exp_words[i], cyc: 0});
      a = a + 10'd1;
    end
    while (a[1:0] != 2'b00) begin
      ex.push_back('{adr: a, data: NOP, cyc: 0});
      a = a + 10'd1;
    end
    check({name, "_nwrites"}, 64'(wq.size()), 64'(ex.size()));
    m = (wq.size() < ex.size()) ? wq.size() : ex.size();
    for (int i = 0; i < m; i++) begin
      check($sformatf("%s_adr%0d", name, i), 64'(wq[i].adr), 64'(ex[i].adr));
      check($sformatf("%s_data%0d", name, i), 64'(wq[i].data), 64'(ex[i].data));
    end
    check({name, "_done_pulses"}, 64'(done_cnt), 64'(1));
    if (wq.size() > 0)
      check({name, "_done_timing"}, 64'(done_cyc), 64'(wq[wq.size()-1].cyc + 1));
    $display("[TB] block %s: %0d writes, %0d done pulses", name, wq.size(), done_cnt);
  endtask

  task automatic check_reset_outputs(input string name);
    @(negedge clk);
    check({name, "_waiting"}, 64'(waiting), 64'(1));
    check({name, "_we"}, 64'(oram_we), 64'(0));
    check({name, "_adr"}, 64'(oram_adr), 64'(0));
    check({name, "_data"}, 64'(oram_data), 64'(0));
    check({name, "_done"}, 64'(done), 64'(0));
    check({name, "_ovf"}, 64'(oram_ovf), 64'(0));
  endtask

  typedef struct {
    logic        st;
    logic [9:0]  base;
    logic        valid;
    logic [31:0] word;
    logic        fl;
    logic        e_wait;
    logic        e_we;
    logic [9:0]  e_adr;
    logic [31:0] e_data;
    logic        e_done;
  } vec_t;

  vec_t vec [12];
  logic [31:0] bp [5];
  logic        exp_wait;
  int          idx;
  logic        acc;

  initial begin
    // Streaming + flush/pad, cycle by cycle. Expected outputs reflect the
    // inputs of earlier steps (registered outputs).
    vec[0]  = '{1, 10'h010, 0, 32'h0,        0, 1, 0, 10'h000, 32'h0,        0};
    vec[1]  = '{0, 10'h000, 1, 32'hE3A00001, 0, 0, 0, 10'h000, 32'h0,        0};
    vec[2]  = '{0, 10'h000, 1, 32'hE3A00002, 0, 0, 0, 10'h000, 32'h0,        0};
    vec[3]  = '{0, 10'h000, 1, 32'hE3A00003, 0, 0, 1, 10'h010, 32'hE3A00001, 0};
    vec[4]  = '{0, 10'h000, 0, 32'h0,        0, 0, 1, 10'h011, 32'hE3A00002, 0};
    vec[5]  = '{0, 10'h000, 0, 32'h0,        0, 0, 1, 10'h012, 32'hE3A00003, 0};
    vec[6]  = '{0, 10'h000, 0, 32'h0,        1, 0, 0, 10'h000, 32'h0,        0};
    vec[7]  = '{0, 10'h000, 0, 32'h0,        0, 1, 0, 10'h000, 32'h0,        0};
    vec[8]  = '{0, 10'h000, 0, 32'h0,        0, 1, 0, 10'h000, 32'h0,        0};
    vec[9]  = '{0, 10'h000, 0, 32'h0,        0, 1, 1, 10'h013, NOP,          0};
    vec[10] = '{0, 10'h000, 0, 32'h0,        0, 1, 0, 10'h000, 32'h0,        1};
    vec[11] = '{0, 10'h000, 0, 32'h0,        0, 1, 0, 10'h000, 32'h0,        0};

    reset = 1'b1; start = 1'b0; base_adr = '0; cmd_valid = 1'b0; cmd_word = '0;
    cmd_imm_en = 1'b0; imm_data = '0; flush = 1'b0; oram_ready = 1'b1;

    // Reset and idle
    repeat (3) tick();
    reset = 1'b0;
    check_reset_outputs("reset");
    wq.delete();
    cmd_valid = 1'b1;
    cmd_word  = 32'hDEADBEEF;
    repeat (3) begin
      tick();
      @(negedge clk);
      check("idle_waiting", 64'(waiting), 64'(1));
    end
    check("idle_no_writes", 64'(wq.size()), 64'(0));
    tick();
    cmd_valid = 1'b0;

    // Streaming table
    for (int i = 0; i < 12; i++) begin
      start     = vec[i].st;
      base_adr  = vec[i].base;
      cmd_valid = vec[i].valid;
      cmd_word  = vec[i].word;
      flush     = vec[i].fl;
      @(negedge clk);
      $display("[TB] vec %0d waiting=%b we=%b adr=%h data=%h done=%b",
               i, waiting, oram_we, oram_adr, oram_data, done);
      check($sformatf("vec%0d_waiting", i), 64'(waiting), 64'(vec[i].e_wait));
      check($sformatf("vec%0d_we", i), 64'(oram_we), 64'(vec[i].e_we));
      if (vec[i].e_we) begin
        check($sformatf("vec%0d_adr", i), 64'(oram_adr), 64'(vec[i].e_adr));
        check($sformatf("vec%0d_data", i), 64'(oram_data), 64'(vec[i].e_data));
      end
      check($sformatf("vec%0d_done", i), 64'(done), 64'(vec[i].e_done));
      @(posedge clk);
      #1;
    end
    start = 1'b0; cmd_valid = 1'b0; flush = 1'b0;
    tick();

    // Flush and pad: 5 words from 0x020
    start_block(10'h020);
    for (int i = 0; i < 5; i++) begin
      exp_words[i] = 32'hE3A00100 + 32'(i);
      push_word(exp_words[i], 1'b0, 8'h00);
    end
    pulse_flush();
    wait_done("pad5");
    verify_block("pad5", 10'h020, 5);

    // Exactly 4 words: no pad
    start_block(10'h030);
    for (int i = 0; i < 4; i++) begin
      exp_words[i] = 32'hE3A00200 + 32'(i);
      push_word(exp_words[i], 1'b0, 8'h00);
    end
    pulse_flush();
    wait_done("nopad4");
    verify_block("nopad4", 10'h030, 4);

    // Back-pressure: oram_ready low, 5 words offered continuously
    oram_ready = 1'b0;
    start_block(10'h040);
    for (int i = 0; i < 5; i++) begin
      bp[i] = 32'hE3A00300 + 32'(i);
      exp_words[i] = bp[i];
    end
    idx = 0;
    cmd_valid = 1'b1;
    cmd_word  = bp[0];
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      exp_wait = (c >= 3);
      check($sformatf("bp_waiting%0d", c), 64'(waiting), 64'(exp_wait));
      acc = !waiting;
      @(posedge clk);
      #1;
      if (acc) begin
        idx = idx + 1;
        if (idx < 5) cmd_word = bp[idx];
      end
    end
    check("bp_accepted", 64'(idx), 64'(3));
    check("bp_no_writes", 64'(wq.size()), 64'(0));
    oram_ready = 1'b1;
    for (int k = 3; k < 5; k++) push_word(bp[k], 1'b0, 8'h00);
    pulse_flush();
    wait_done("bp");
    verify_block("bp", 10'h040, 5);

    // Address wrap and immediate merge
    start_block(10'h3FF);
    exp_words[0] = 32'hE3A00021;
`ifdef EMIT_IMM_MERGE_EN
    exp_words[1] = 32'hE3A0002A;
`else
    exp_words[1] = 32'hE3A000FF;
`endif
    push_word(32'hE3A00021, 1'b0, 8'h00);
    push_word(32'hE3A000FF, 1'b1, 8'h2A);
    pulse_flush();
    wait_done("wrap");
    verify_block("wrap", 10'h3FF, 2);
    @(negedge clk);
    check("wrap_ovf_set", 64'(oram_ovf), 64'(1));
    tick();

    // New block clears ovf; aligned empty flush pads nothing
    start_block(10'h080);
    @(negedge clk);
    check("start_clears_ovf", 64'(oram_ovf), 64'(0));
    tick();
    pulse_flush();
    wait_done("empty");
    verify_block("empty", 10'h080, 0);

    // Mid-operation reset with 3 words buffered
    oram_ready = 1'b0;
    start_block(10'h050);
    for (int i = 0; i < 3; i++) push_word(32'hE3A00400 + 32'(i), 1'b0, 8'h00);
    reset = 1'b1;
    tick();
    check_reset_outputs("midreset");
    reset = 1'b0;
    oram_ready = 1'b1;
    repeat (5) tick();
    check("midreset_no_writes", 64'(wq.size()), 64'(0));
    // Buffered words must be gone: an aligned empty block emits nothing.
    start_block(10'h060);
    pulse_flush();
    wait_done("postreset");
    verify_block("postreset", 10'h060, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
